// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stimulus driver: opcodes, button encodings, FSM states.
package alu_pkg;

    // Opcodes understood by the target ALU
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // One-hot load buttons
    localparam logic [2:0] BTN_A  = 3'b100;
    localparam logic [2:0] BTN_B  = 3'b010;
    localparam logic [2:0] BTN_OP = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PH_A  = 2'd0,
        PH_B  = 2'd1,
        PH_OP = 2'd2
    } phase_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference of the target ALU: expected result for operands and opcode.
// o_known is low for opcodes the ALU does not define.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int N_BITS = 6,
    parameter int N_LEDS = 6
) (
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic [N_BITS-1:0] i_op,
    output logic [N_LEDS-1:0] o_expected,
    output logic              o_known
);

    logic [N_BITS-1:0] res;

    // Decode opcode and compute the ALU result; shifts by >= N_BITS fill naturally
    always_comb begin
        res     = '0;
        o_known = 1'b1;
        case (i_op)
            N_BITS'(OP_ADD): res = i_a + i_b;
            N_BITS'(OP_SUB): res = i_a - i_b;
            N_BITS'(OP_AND): res = i_a & i_b;
            N_BITS'(OP_OR):  res = i_a | i_b;
            N_BITS'(OP_XOR): res = i_a ^ i_b;
            N_BITS'(OP_NOR): res = ~(i_a | i_b);
            N_BITS'(OP_SRA): res = $unsigned($signed(i_a) >>> i_b);
            N_BITS'(OP_SRL): res = i_a >> i_b;
            default:         o_known = 1'b0;
        endcase
        o_expected = N_LEDS'(res);
    end

endmodule

// File: rtl/alu_stim_driver.sv
// Replays the A / B / OP switch+button load protocol into the ALU from a parallel
// request, then captures the LED result after RESULT_LAT cycles with a valid pulse.
// Optional self-check of the captured result: define ALU_DRV_CHECK_EN.
// Handshake: a request is taken on a clock edge where i_start=1 and the FSM is idle;
// o_valid marks the single cycle in which o_result (and o_mismatch) are new.
module alu_stim_driver
    import alu_pkg::*;
#(
    parameter int N_BITS       = 6,
    parameter int N_LEDS       = 6,
    parameter int N_B          = 3,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 1,
    parameter int RESULT_LAT   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_data_a,
    input  logic [N_BITS-1:0] i_data_b,
    input  logic [N_BITS-1:0] i_op,
    input  logic [N_LEDS-1:0] i_led,
    output logic [N_BITS-1:0] o_sw,
    output logic [N_B-1:0]    o_buttons,
    output logic              o_busy,
    output logic [N_LEDS-1:0] o_result,
    output logic              o_valid,
    output logic              o_mismatch,
    output logic [2:0]        o_dbg_state
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RESULT_LAT - 1);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_BITS-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
    logic [N_BITS-1:0] sw_q, sw_d;
    logic [N_B-1:0]    buttons_q, buttons_d;
    logic              busy_q, busy_d;
    logic [N_LEDS-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              mismatch_q, mismatch_d;
    logic [N_BITS-1:0] phase_val;
    logic [N_B-1:0]    phase_btn;
    logic              chk_mismatch;

`ifdef ALU_DRV_CHECK_EN
    logic [N_LEDS-1:0] exp_led;
    logic              exp_known;

    alu_ref_model #(.N_BITS(N_BITS), .N_LEDS(N_LEDS)) u_ref (
        .i_a        (a_q),
        .i_b        (b_q),
        .i_op       (op_q),
        .o_expected (exp_led),
        .o_known    (exp_known)
    );

    // Unknown opcodes never flag a mismatch
    assign chk_mismatch = exp_known && (i_led != exp_led);
`else
    assign chk_mismatch = 1'b0;
`endif

    // Switch value and button for the operand phase currently being loaded
    always_comb begin
        phase_val = op_q;
        phase_btn = N_B'(BTN_OP);
        case (phase_q)
            PH_A: begin phase_val = a_q; phase_btn = N_B'(BTN_A); end
            PH_B: begin phase_val = b_q; phase_btn = N_B'(BTN_B); end
            default: ;
        endcase
    end

    // Next state, request latching and output values; outputs trail the state by one edge
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sw_d       = sw_q;
        buttons_d  = '0;
        busy_d     = 1'b0;
        result_d   = result_q;
        valid_d    = 1'b0;
        mismatch_d = mismatch_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d     = i_data_a;
                    b_d     = i_data_b;
                    op_d    = i_op;
                    phase_d = PH_A;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                sw_d   = phase_val;
                busy_d = 1'b1;
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PULSE: begin
                sw_d      = phase_val;
                buttons_d = phase_btn;
                busy_d    = 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                sw_d   = phase_val;
                busy_d = 1'b1;
                cnt_d  = '0;
                if (phase_q == PH_OP) begin
                    state_d = ST_WAIT;
                end else begin
                    phase_d = (phase_q == PH_A) ? PH_B : PH_OP;
                    state_d = ST_SETUP;
                end
            end
            ST_WAIT: begin
                sw_d   = op_q;
                busy_d = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                result_d   = i_led;
                valid_d    = 1'b1;
                mismatch_d = chk_mismatch;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any sequence immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_A;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sw_q       <= '0;
            buttons_q  <= '0;
            busy_q     <= 1'b0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            sw_q       <= sw_d;
            buttons_q  <= buttons_d;
            busy_q     <= busy_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign o_sw        = sw_q;
    assign o_buttons   = buttons_q;
    assign o_busy      = busy_q;
    assign o_result    = result_q;
    assign o_valid     = valid_q;
    assign o_mismatch  = mismatch_q;
    assign o_dbg_state = state_q;

endmodule
